// File: rtl/jc_link_tx_pkg.sv
// Shared definitions for the JC inter-board link transmitter.
package jc_link_pkg;

   // Command type codes carried on cmd_type
   typedef enum logic [1:0] {
      CMD_TILT = 2'b00,
      CMD_FIRE = 2'b01,
      CMD_RST  = 2'b10,
      CMD_MODE = 2'b11
   } cmd_type_e;

   // Bit positions on the active-low JC header
   localparam int unsigned JC_RST     = 4;
   localparam int unsigned JC_MODE    = 3;
   localparam int unsigned JC_FIRE    = 2;
   localparam int unsigned JC_TILT_HI = 1;
   localparam int unsigned JC_TILT_LO = 0;

   // Link control states
   typedef enum logic [1:0] {
      ONBOARD  = 2'b00,
      PHONE    = 2'b01,
      RSTPULSE = 2'b10
   } state_e;

endpackage

// File: rtl/jc_link_tx_if.sv
// Command handshake from the phone command decoder to the JC transmitter.
interface jc_link_tx_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_type;
   logic [1:0] cmd_arg;

   modport master (output cmd_valid, output cmd_type, output cmd_arg, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_type, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/jc_link_tx_pulse_timer.sv
// Saturating down-counter that times one pulse; load restarts it, clear cancels it.
module jc_pulse_timer #(
   parameter int unsigned CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic clear,
   output logic active,
   output logic expiring
);
   localparam int unsigned W = $clog2(CYCLES + 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear beats load, load beats the decrement, stop at zero
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = W'(CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign active   = (cnt_q != '0);
   assign expiring = (cnt_q == W'(1));

endmodule

// File: rtl/jc_link_tx.sv
// JC link transmitter: turns accepted phone commands into registered,
// time-shaped active-low control lines for the Hunter's Paradise board.
module jc_link_tx
   import jc_link_pkg::*;
#(
   parameter int unsigned FIRE_CYCLES    = 5_000_000,
   parameter int unsigned RESET_CYCLES   = 10_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
   input  logic             clk,
   input  logic             reset,
   jc_link_tx_if.slave      cmd,
   output logic [7:0]       jc,
   output logic             link_mode
);

   state_e      state_q, state_d;
   logic [7:0]  jc_q, jc_d;
   logic        link_q, link_d;
   logic        ready_q, ready_d;
   logic [1:0]  tilt_d;
   logic        accept, leave, in_phone_d;

   logic fire_load, fire_clear, fire_active, fire_expiring;
   logic rst_load, rst_active, rst_expiring;
   logic to_load, to_clear, to_active, to_expiring;

   jc_pulse_timer #(.CYCLES(FIRE_CYCLES)) u_fire (
      .clk      (clk),
      .reset    (reset),
      .load     (fire_load),
      .clear    (fire_clear),
      .active   (fire_active),
      .expiring (fire_expiring)
   );

   jc_pulse_timer #(.CYCLES(RESET_CYCLES)) u_rst (
      .clk      (clk),
      .reset    (reset),
      .load     (rst_load),
      .clear    (1'b0),
      .active   (rst_active),
      .expiring (rst_expiring)
   );

   jc_pulse_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .load     (to_load),
      .clear    (to_clear),
      .active   (to_active),
      .expiring (to_expiring)
   );

   // Next state, timer controls and the next JC byte
   always_comb begin
      state_d   = state_q;
      fire_load = 1'b0;
      rst_load  = 1'b0;
      to_load   = 1'b0;
      leave     = 1'b0;
      tilt_d    = jc_q[JC_TILT_HI:JC_TILT_LO];
      accept    = cmd.cmd_valid & ready_q;

      unique case (state_q)
         ONBOARD: begin
            if (accept) begin
               if (cmd.cmd_type == CMD_MODE && cmd.cmd_arg[0]) begin
                  state_d = PHONE;
                  to_load = 1'b1;
                  tilt_d  = 2'b11;
               end else if (cmd.cmd_type == CMD_RST) begin
                  state_d  = RSTPULSE;
                  rst_load = 1'b1;
               end
            end
         end
         PHONE: begin
            // An accepted command outranks a timeout expiring in the same cycle
            if (accept) begin
               to_load = 1'b1;
               case (cmd.cmd_type)
                  CMD_TILT: tilt_d = ~cmd.cmd_arg;
                  CMD_FIRE: fire_load = 1'b1;
                  CMD_RST: begin
                     state_d  = RSTPULSE;
                     rst_load = 1'b1;
                     leave    = 1'b1;
                  end
                  CMD_MODE: begin
                     if (!cmd.cmd_arg[0]) begin
                        state_d = ONBOARD;
                        leave   = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end else if (to_expiring || !to_active) begin
               state_d = ONBOARD;
               leave   = 1'b1;
            end
         end
         RSTPULSE: begin
            if (rst_expiring || !rst_active) begin
               state_d = ONBOARD;
            end
         end
         default: state_d = ONBOARD;
      endcase

      fire_clear = leave;
      to_clear   = leave;

      in_phone_d = (state_d == PHONE);
      jc_d                          = '1;
      jc_d[JC_RST]                  = (state_d != RSTPULSE);
      jc_d[JC_MODE]                 = ~in_phone_d;
      jc_d[JC_FIRE]                 = ~(in_phone_d & (fire_load | (fire_active & ~fire_expiring)));
      jc_d[JC_TILT_HI:JC_TILT_LO]   = in_phone_d ? tilt_d : 2'b11;
      link_d                        = in_phone_d;
      ready_d                       = (state_d != RSTPULSE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ONBOARD;
         jc_q    <= 8'hFF;
         link_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         jc_q    <= jc_d;
         link_q  <= link_d;
         ready_q <= ready_d;
      end
   end

   assign jc            = jc_q;
   assign link_mode     = link_q;
   assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_jc_link_tx.sv
// Directed bench for jc_link_tx with short pulse/timeout parameters.
module tb_jc_link_tx;
   import jc_link_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] jc;
   logic       link_mode;

   int unsigned errors = 0;
   int unsigned checks = 0;

   jc_link_tx_if cmd_if ();

   jc_link_tx #(
      .FIRE_CYCLES    (4),
      .RESET_CYCLES   (6),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd       (cmd_if),
      .jc        (jc),
      .link_mode (link_mode)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst;
      logic       v;
      logic [1:0] t;
      logic [1:0] a;
      logic [7:0] jc;
      logic       rdy;
      logic       lm;
   } vec_t;

   vec_t vt [28];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of command inputs and return just after the edge
   task automatic step(input logic v, input logic [1:0] t, input logic [1:0] a);
      cmd_if.cmd_valid = v;
      cmd_if.cmd_type  = t;
      cmd_if.cmd_arg   = a;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input logic [7:0] ejc, input logic erdy, input logic elm);
      chk({name, " jc"}, jc, ejc);
      chk({name, " ready"}, {7'b0, cmd_if.cmd_ready}, {7'b0, erdy});
      chk({name, " link_mode"}, {7'b0, link_mode}, {7'b0, elm});
   endtask

   initial begin
      reset            = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_type  = 2'b00;
      cmd_if.cmd_arg   = 2'b00;

      //            rst   v     type   arg    jc     rdy   lm
      vt[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 8'hFF, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b1, 2'b11, 2'b01, 8'hFF, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 2'b00, 2'b00, 8'hFF, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 2'b00, 2'b01, 8'hFF, 1'b1, 1'b0}; // tilt dropped
      vt[4]  = '{1'b0, 1'b1, 2'b01, 2'b00, 8'hFF, 1'b1, 1'b0}; // fire dropped
      vt[5]  = '{1'b0, 1'b1, 2'b11, 2'b00, 8'hFF, 1'b1, 1'b0}; // leave dropped
      vt[6]  = '{1'b0, 1'b1, 2'b11, 2'b01, 8'hF7, 1'b1, 1'b1}; // enter phone
      vt[7]  = '{1'b0, 1'b1, 2'b00, 2'b10, 8'hF5, 1'b1, 1'b1};
      vt[8]  = '{1'b0, 1'b1, 2'b00, 2'b11, 8'hF4, 1'b1, 1'b1};
      vt[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 8'hF7, 1'b1, 1'b1};
      vt[10] = '{1'b0, 1'b1, 2'b01, 2'b11, 8'hF3, 1'b1, 1'b1}; // fire
      vt[11] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'hF3, 1'b1, 1'b1};
      vt[12] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'hF3, 1'b1, 1'b1};
      vt[13] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'hF3, 1'b1, 1'b1};
      vt[14] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'hF7, 1'b1, 1'b1}; // fire ends
      vt[15] = '{1'b0, 1'b1, 2'b01, 2'b00, 8'hF3, 1'b1, 1'b1};
      vt[16] = '{1'b0, 1'b1, 2'b11, 2'b00, 8'hFF, 1'b1, 1'b0}; // leave cancels fire
      vt[17] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'hFF, 1'b1, 1'b0};
      vt[18] = '{1'b0, 1'b1, 2'b11, 2'b11, 8'hF7, 1'b1, 1'b1};
      vt[19] = '{1'b0, 1'b1, 2'b10, 2'b01, 8'hEF, 1'b0, 1'b0}; // game reset
      vt[20] = '{1'b0, 1'b1, 2'b11, 2'b01, 8'hEF, 1'b0, 1'b0};
      vt[21] = '{1'b0, 1'b1, 2'b11, 2'b01, 8'hEF, 1'b0, 1'b0};
      vt[22] = '{1'b0, 1'b1, 2'b11, 2'b01, 8'hEF, 1'b0, 1'b0};
      vt[23] = '{1'b0, 1'b1, 2'b11, 2'b01, 8'hEF, 1'b0, 1'b0};
      vt[24] = '{1'b0, 1'b1, 2'b11, 2'b01, 8'hEF, 1'b0, 1'b0};
      vt[25] = '{1'b0, 1'b1, 2'b11, 2'b01, 8'hFF, 1'b1, 1'b0}; // pulse over
      vt[26] = '{1'b0, 1'b1, 2'b11, 2'b01, 8'hF7, 1'b1, 1'b1};
      vt[27] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'hF7, 1'b1, 1'b1};

      for (int i = 0; i < 28; i++) begin
         reset = vt[i].rst;
         step(vt[i].v, vt[i].t, vt[i].a);
         chk_all($sformatf("vec%0d", i), vt[i].jc, vt[i].rdy, vt[i].lm);
      end

      // Idle line stays at FF for 30 cycles in ONBOARD
      step(1'b1, CMD_MODE, 2'b00);
      for (int k = 0; k < 30; k++) step(1'b0, CMD_TILT, 2'b00);
      chk("idle30 jc", jc, 8'hFF);

      // Fire at t and t+2: low through t+6, high at t+7
      step(1'b1, CMD_MODE, 2'b01);
      chk("retrig enter", jc, 8'hF7);
      step(1'b1, CMD_FIRE, 2'b00);
      chk("retrig t+1", {7'b0, jc[JC_FIRE]}, 8'h00);
      step(1'b0, CMD_TILT, 2'b00);
      chk("retrig t+2", {7'b0, jc[JC_FIRE]}, 8'h00);
      step(1'b1, CMD_FIRE, 2'b10);
      chk("retrig t+3", {7'b0, jc[JC_FIRE]}, 8'h00);
      for (int k = 4; k <= 6; k++) begin
         step(1'b0, CMD_TILT, 2'b00);
         chk($sformatf("retrig t+%0d", k), {7'b0, jc[JC_FIRE]}, 8'h00);
      end
      step(1'b0, CMD_TILT, 2'b00);
      chk("retrig t+7", jc, 8'hF7);

      // Timeout 20 cycles after last accepted command
      step(1'b1, CMD_TILT, 2'b01);
      chk("timeout tilt", jc, 8'hF6);
      for (int k = 1; k <= 19; k++) step(1'b0, CMD_TILT, 2'b00);
      chk_all("timeout k19", 8'hF6, 1'b1, 1'b1);
      step(1'b0, CMD_TILT, 2'b00);
      chk_all("timeout k20", 8'hFF, 1'b1, 1'b0);

      // Command accepted on the expiry cycle wins
      step(1'b1, CMD_MODE, 2'b01);
      for (int k = 1; k <= 19; k++) step(1'b0, CMD_TILT, 2'b00);
      step(1'b1, CMD_TILT, 2'b00);
      chk_all("expiry tilt", 8'hF7, 1'b1, 1'b1);
      for (int k = 1; k <= 19; k++) step(1'b0, CMD_TILT, 2'b00);
      chk("expiry reload k19", jc, 8'hF7);
      step(1'b0, CMD_TILT, 2'b00);
      chk("expiry reload k20", jc, 8'hFF);

      // Game reset from PHONE with fire active
      step(1'b1, CMD_MODE, 2'b01);
      step(1'b1, CMD_FIRE, 2'b00);
      chk("grst fire", jc, 8'hF3);
      step(1'b1, CMD_RST, 2'b11);
      chk_all("grst c1", 8'hEF, 1'b0, 1'b0);
      for (int k = 2; k <= 6; k++) begin
         step(1'b0, CMD_TILT, 2'b00);
         chk($sformatf("grst c%0d jc", k), jc, 8'hEF);
         chk($sformatf("grst c%0d ready", k), {7'b0, cmd_if.cmd_ready}, 8'h00);
      end
      step(1'b0, CMD_TILT, 2'b00);
      chk_all("grst end", 8'hFF, 1'b1, 1'b0);
      step(1'b1, CMD_TILT, 2'b00);
      chk("grst onboard", jc, 8'hFF);

      // Reset asserted on the 3rd cycle of a reset pulse
      step(1'b1, CMD_RST, 2'b00);
      chk("abort c1", jc, 8'hEF);
      step(1'b0, CMD_TILT, 2'b00);
      chk("abort c2", jc, 8'hEF);
      reset = 1'b1;
      step(1'b0, CMD_TILT, 2'b00);
      chk_all("abort reset", 8'hFF, 1'b0, 1'b0);
      reset = 1'b0;
      step(1'b0, CMD_TILT, 2'b00);
      chk_all("abort release", 8'hFF, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, CMD_TILT, 2'b00);
         chk($sformatf("abort idle%0d", k), jc, 8'hFF);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
